ks_sub8_pipe: RTL and testbench
===============================

# ks_sub8_pipe

Pipelined 8-bit Kogge-Stone subtractor with borrow-in/borrow-out and a valid/ready handshake on both sides. It is the subtract-direction companion to the team's combinational Kogge-Stone adder: it computes a − b − bin, reports borrow, signed overflow and zero, and registers each prefix level so the ALU datapath can close timing at higher clock rates. It sits between the operand-issue stage and the result writeback stage, and accepts one operation per clock when not stalled.

## Interface
- W, 8: operand width; only 8 is supported, giving log2(W) = 3 prefix levels.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept an operand set this cycle.
- a  in  W  minuend.
- b  in  W  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- d  out  W  difference, a − b − bin mod 2^W.
- bout  out  1  borrow-out; high when unsigned a < b + bin.
- ovf  out  1  two's-complement overflow of the subtraction.
- zero  out  1  high when d == 0.

## Operation
- Arithmetic is d = a + ~b + cin with cin = ~bin.
  - Per bit: g_i = a_i & ~b_i, p_i = a_i ^ ~b_i.
  - bout = ~c_W, where c_W is the carry out of bit W−1.
  - ovf = c_W ^ c_{W−1}.
  - d_i = p_i ^ c_i, with c_0 = cin.
- Prefix network follows standard Kogge-Stone spans of 1, 2 and 4 with cin folded in as position −1.
  - Grey cells resolve group carries that include cin.
  - Black cells carry (G, P) pairs.
- Pipeline registers:
  - S1: g/p and cin captured at input acceptance.
  - S2: level-1 result.
  - S3: level-2 result.
  - OUT: level-3 result plus the sum XOR and flags.
- Each register holds a valid bit.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
- While stalled, all stages hold their contents.
- Bubbles (invalid stages) are not compressed. This keeps control a single global enable.
- While in_ready is low, a, b and bin are ignored. The upstream side must hold them until the transfer.
- No reordering and no dropping. Results emerge in acceptance order.

## Timing
- Latency: an operand set accepted at rising edge k gives out_valid = 1 with its result after edge k+3, provided no stall occurs in between.
- Throughput: one result per cycle while out_ready stays high.
- Reset, asynchronous, takes effect immediately:
  - all valid bits = 0, so out_valid = 0;
  - d = 0, bout = 0, ovf = 0, zero = 0;
  - in_ready = 1.
- Reset mid-operation discards all in-flight operations. No partial result appears after rst_n deasserts.
- While out_valid = 0, the outputs d, bout, ovf and zero hold their last values and are don't-care.
- If out_ready is high in the same cycle as a stall would clear, the pipeline advances and in_ready is already high in that cycle. There is no one-cycle bubble.
- If in_valid is high while in_ready is low, nothing is captured and nothing is lost. The upstream side holds its data.

## Structure
- Shared package `ks_pkg`:
  - constant KS_W = 8;
  - constant KS_LEVELS = 3;
  - typedef `gp_t`, a struct of g and p, each W bits wide;
  - typedef `sub_flags_t`, a struct of bout, ovf and zero.
- One sub-module, `ks_prefix_level`, parameterised by span. It is one combinational Kogge-Stone level of grey and black cells and is instantiated three times between the pipeline registers.
- Handshake and valid-bit control stays in the top module.

## Test plan
- Reset, then a=0x05, b=0x03, bin=0 → after 3 cycles: d=0x02, bout=0, ovf=0, zero=0.
- a=0x00, b=0x01, bin=0 → d=0xFF, bout=1, ovf=0. Then a=0x80, b=0x01 → d=0x7F, bout=0, ovf=1.
- a=0x10, b=0x0F, bin=1 → d=0x00, zero=1, bout=0. Also a=0x00, b=0x00, bin=1 → d=0xFF, bout=1.
- 16 back-to-back operations with out_ready=1 → 16 consecutive out_valid cycles, starting 3 cycles after the first acceptance, all values matching a reference model.
- Hold out_ready=0 for 5 cycles with the pipeline full → in_ready=0, out_valid stays 1, d is stable. On release, the remaining results drain in order with none lost or duplicated.
- Assert rst_n=0 mid-stream with 3 operations in flight → out_valid falls immediately. After release, no stale result appears and the next operation completes with 3-cycle latency.

Source files
------------

// File: rtl/ks_pkg.sv
// ks_pkg - shared types and constants for the Kogge-Stone subtractor.
//   KS_W        operand width (8 only)
//   KS_LEVELS   number of prefix levels, log2(KS_W)
//   gp_t        per-bit generate/propagate vectors
//   sub_flags_t borrow-out, signed overflow and zero flags
package ks_pkg;

    localparam int KS_W      = 8;
    localparam int KS_LEVELS = 3;

    typedef struct packed {
        logic [KS_W-1:0] g;
        logic [KS_W-1:0] p;
    } gp_t;

    typedef struct packed {
        logic bout;
        logic ovf;
        logic zero;
    } sub_flags_t;

endpackage

// File: rtl/ks_prefix_level.sv
// ks_prefix_level - one combinational Kogge-Stone prefix level.
//   SPAN    distance to the lower partner bit (1, 2 or 4)
//   gp_in   group (G, P) pairs from the previous level
//   gp_out  group (G, P) pairs after this level
// Bits below SPAN already cover bit 0 (and therefore the folded carry-in),
// so they pass through. Bits whose partner is one of those are grey cells:
// their G becomes a final carry and their P is no longer needed. The rest
// are black cells that combine both G and P.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int SPAN = 1
) (
    input  gp_t gp_in,
    output gp_t gp_out
);

    logic [KS_W-1:0] g_o;
    logic [KS_W-1:0] p_o;

    for (genvar j = 0; j < KS_W; j++) begin : g_bit
        if (j >= SPAN) begin : g_cell
            assign g_o[j] = gp_in.g[j] | (gp_in.p[j] & gp_in.g[j-SPAN]);
            assign p_o[j] = gp_in.p[j] & gp_in.p[j-SPAN];
        end else begin : g_pass
            assign g_o[j] = gp_in.g[j];
            assign p_o[j] = gp_in.p[j];
        end
    end

    always_comb begin
        gp_out.g = g_o;
        gp_out.p = p_o;
    end

endmodule

// File: rtl/ks_sub8_pipe.sv
// ks_sub8_pipe - pipelined 8-bit Kogge-Stone subtractor, d = a - b - bin.
//   clk, rst_n           clock, async active-low reset
//   in_valid, in_ready   operand handshake (a, b, bin)
//   out_valid, out_ready result handshake (d, bout, ovf, zero)
// Stages: S1 captures raw g/p and cin, S2/S3 hold prefix levels 1 and 2,
// OUT holds level 3 plus the sum and flags. Every stage advances on a single
// global enable (no stall), so bubbles are kept rather than compressed.
module ks_sub8_pipe
    import ks_pkg::*;
#(
    parameter int W = KS_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    logic       stall;
    logic       en;

    logic       s1_valid, s2_valid, s3_valid, out_valid_q;
    gp_t        s1_gp;
    logic       s1_cin, s2_cin, s3_cin;
    gp_t        s2_gp, s3_gp;
    logic [W-1:0] s2_p, s3_p;

    logic [W-1:0] d_q;
    sub_flags_t   flags_q;

    gp_t        lvl_in  [KS_LEVELS];
    gp_t        lvl_out [KS_LEVELS];

    logic [W-1:0] carry;
    logic [W-1:0] d_next;
    sub_flags_t   flags_next;

    assign stall    = out_valid_q & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;

    // cin sits at position -1; folding it into bit 0 with a grey cell before
    // level 1 lets three levels (spans 1, 2, 4) resolve every carry.
    always_comb begin
        lvl_in[0].g = {s1_gp.g[W-1:1], s1_gp.g[0] | (s1_gp.p[0] & s1_cin)};
        lvl_in[0].p = s1_gp.p;
    end
    assign lvl_in[1] = s2_gp;
    assign lvl_in[2] = s3_gp;

    for (genvar i = 0; i < KS_LEVELS; i++) begin : g_level
        ks_prefix_level #(.SPAN(1 << i)) u_level (
            .gp_in  (lvl_in[i]),
            .gp_out (lvl_out[i])
        );
    end

    // Final G of bit i is the carry into bit i+1.
    assign carry  = {lvl_out[2].g[W-2:0], s3_cin};
    assign d_next = s3_p ^ carry;

    always_comb begin
        flags_next.bout = ~lvl_out[2].g[W-1];
        flags_next.ovf  = lvl_out[2].g[W-1] ^ lvl_out[2].g[W-2];
        flags_next.zero = (d_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            s3_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            s1_gp       <= '0;
            s1_cin      <= 1'b0;
            s2_gp       <= '0;
            s2_p        <= '0;
            s2_cin      <= 1'b0;
            s3_gp       <= '0;
            s3_p        <= '0;
            s3_cin      <= 1'b0;
            d_q         <= '0;
            flags_q     <= '0;
        end else if (en) begin
            s1_valid    <= in_valid;
            s2_valid    <= s1_valid;
            s3_valid    <= s2_valid;
            out_valid_q <= s3_valid;
            if (in_valid) begin
                s1_gp.g <= a & ~b;
                s1_gp.p <= a ^ ~b;
                s1_cin  <= ~bin;
            end
            s2_gp  <= lvl_out[0];
            s2_p   <= s1_gp.p;
            s2_cin <= s1_cin;
            s3_gp  <= lvl_out[1];
            s3_p   <= s2_p;
            s3_cin <= s2_cin;
            // Output data only moves with a real result, so it holds otherwise.
            if (s3_valid) begin
                d_q     <= d_next;
                flags_q <= flags_next;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bout      = flags_q.bout;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;

endmodule

// File: tb/tb_ks_sub8_pipe.sv
// tb_ks_sub8_pipe - self-checking bench for ks_sub8_pipe.
// Expected results come from a 9-bit arithmetic model, pushed to a queue on
// input acceptance and popped when a result transfers out.
module tb_ks_sub8_pipe;

    typedef struct packed {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
        logic       zero;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
    logic       zero;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_recv   = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    ks_sub8_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic bi);
        logic [8:0] t;
        res_t       r;
        t      = {1'b0, x} - {1'b0, y} - {8'b0, bi};
        r.d    = t[7:0];
        r.bout = t[8];
        r.ovf  = (x[7] != y[7]) && (r.d[7] != x[7]);
        r.zero = (r.d == 8'h00);
        return r;
    endfunction

    // Scoreboard: sample both handshakes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb.push_back(model(a, b, bin));
            if (out_valid && out_ready) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    res_t e;
                    e = sb.pop_front();
                    chk("sb_d", d, e.d);
                    chk("sb_bout", bout, e.bout);
                    chk("sb_ovf", ovf, e.ovf);
                    chk("sb_zero", zero, e.zero);
                end
                n_recv++;
            end
        end
    end

    task automatic drive_rand();
        a   = 8'($urandom);
        b   = 8'($urandom);
        bin = 1'($urandom);
    endtask

    // Called at posedge+2 with an empty pipeline; returns at posedge+2.
    task automatic issue_dir(input logic [7:0] xa, input logic [7:0] xb, input logic xbin,
                             input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
        in_valid = 1'b1;
        a = xa; b = xb; bin = xbin;
        @(posedge clk);
        #2 in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lat_not_yet", out_valid, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("lat_valid", out_valid, 1'b1);
        chk("dir_d", d, ed);
        chk("dir_bout", bout, eb);
        chk("dir_ovf", ovf, eo);
        chk("dir_zero", zero, ez);
        @(posedge clk);
        #2;
    endtask

    task automatic back_to_back();
        int recv0;
        recv0    = n_recv;
        in_valid = 1'b1;
        drive_rand();
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #2;
            if (i + 1 < 16) drive_rand();
            else in_valid = 1'b0;
            @(negedge clk);
            chk("b2b_valid", out_valid, (i >= 3 && i <= 18));
        end
        chk("b2b_count", n_recv - recv0, 16);
        @(posedge clk);
        #2;
    endtask

    task automatic stall_test();
        int         idx;
        int         recv0;
        logic       acc;
        logic       seen;
        logic [7:0] d_hold;
        recv0     = n_recv;
        out_ready = 1'b0;
        idx       = 0;
        seen      = 1'b0;
        in_valid  = 1'b1;
        drive_rand();
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            acc  = in_valid && in_ready;
            seen = out_valid;
            if (!seen) begin
                @(posedge clk);
                #2;
                if (acc) begin
                    idx++;
                    if (idx < 6) drive_rand();
                    else in_valid = 1'b0;
                end
            end
        end
        chk("stall_full", seen, 1'b1);
        chk("stall_accepted", idx, 4);
        chk("stall_in_ready0", in_ready, 1'b0);
        d_hold = d;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #2;
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_d_hold", d, d_hold);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int c = 0; c < 30 && !(idx >= 6 && sb.size() == 0); c++) begin
            @(negedge clk);
            if (c == 0) chk("release_in_ready", in_ready, 1'b1);
            acc = in_valid && in_ready;
            @(posedge clk);
            #2;
            if (acc) begin
                idx++;
                if (idx < 6) drive_rand();
                else in_valid = 1'b0;
            end
        end
        chk("drain_count", n_recv - recv0, 6);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    task automatic reset_test();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_rand();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            if (i < 2) drive_rand();
            else in_valid = 1'b0;
        end
        @(posedge clk);
        #2;
        chk("rst_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_ready", in_ready, 1'b1);
        chk("rst_async_d", d, 8'h00);
        sb.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #2;
        issue_dir(8'h37, 8'h12, 1'b0, 8'h25, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        bin       = 1'b0;
        #3;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_d", d, 8'h00);
        chk("reset_bout", bout, 1'b0);
        chk("reset_ovf", ovf, 1'b0);
        chk("reset_zero", zero, 1'b0);
        #20;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;

        issue_dir(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        issue_dir(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        issue_dir(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        issue_dir(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        issue_dir(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

        back_to_back();
        stall_test();
        @(posedge clk);
        #2;
        reset_test();

        repeat (3) @(posedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
